// File: rtl/sd_pkg.sv
// -----------------------------------------------------------------------------
// sd_pkg
// Shared definitions for the SD external-block Wishbone bridge:
//   - sd_state_t     : block-transfer state machine encoding
//   - SD_BLOCK_WORDS : 32-bit words in one 512-byte block
//   - SD_BLOCK_SHIFT : log2 of the block size in bytes
//   - sd_word_addr() : byte address of one word of one block
// -----------------------------------------------------------------------------
package sd_pkg;

    localparam int SD_BLOCK_WORDS = 128;
    localparam int SD_BLOCK_SHIFT = 9;
    localparam int SD_WORD_W      = 7;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_BUS   = 3'd1,
        RD_STORE = 3'd2,
        RD_GO    = 3'd3,
        WR_FETCH = 3'd4,
        WR_LAT   = 3'd5,
        WR_BUS   = 3'd6,
        WR_DONE  = 3'd7
    } sd_state_t;

    // Block and word offsets are added in 32-bit arithmetic, so addresses
    // beyond the top of the bus simply wrap around.
    function automatic logic [31:0] sd_word_addr(
        input logic [31:0]          base,
        input logic [31:0]          blk,
        input logic [SD_WORD_W-1:0] word
    );
        logic [31:0] blk_off;
        blk_off = blk << SD_BLOCK_SHIFT;
        return base + blk_off + {23'd0, word, 2'b00};
    endfunction

endpackage

// File: rtl/sd_wb_single.sv
// -----------------------------------------------------------------------------
// sd_wb_single
// Single-word classic Wishbone master engine. A start request launches one
// access; stb is held until the slave terminates it, then drops, so back-to-
// back words always see at least one idle strobe cycle between them.
//
// Ports:
//   clk, reset        clock / synchronous active-high reset
//   start             request a new access (ignored while one is in flight)
//   we, adr, dat_w    access type, byte address, write data (sampled on start)
//   stb_o, we_o,
//   adr_o, dat_o      registered Wishbone master outputs
//   dat_i, ack_i,
//   err_i             Wishbone slave responses
//   done              one-cycle pulse: the current access terminated
//   err_done          one-cycle pulse: the access terminated with an error
//   rdata             registered read data (zero for an errored read)
//
// Build option: SD_EXT_WB_ERR_EN makes err_i terminate an access; otherwise
// err_i is ignored and only ack_i ends an access.
// -----------------------------------------------------------------------------
module sd_wb_single (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        we,
    input  logic [31:0] adr,
    input  logic [31:0] dat_w,
    output logic        stb_o,
    output logic        we_o,
    output logic [31:0] adr_o,
    output logic [31:0] dat_o,
    input  logic [31:0] dat_i,
    input  logic        ack_i,
    input  logic        err_i,
    output logic        done,
    output logic        err_done,
    output logic [31:0] rdata
);

    logic        stb_q, stb_d;
    logic        we_q, we_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_eff;
    logic        hit;

`ifdef SD_EXT_WB_ERR_EN
    assign err_eff = err_i;
`else
    logic unused_err_i;
    assign unused_err_i = err_i;
    assign err_eff      = 1'b0;
`endif

    // A response only counts while our strobe is actually out.
    assign hit = stb_q & (ack_i | err_eff);

    always_comb begin
        stb_d   = stb_q;
        we_d    = we_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        rdata_d = rdata_q;
        if (hit) begin
            stb_d = 1'b0;
            if (!we_q) begin
                rdata_d = err_eff ? 32'h0 : dat_i;
            end
        end else if (start && !stb_q) begin
            stb_d = 1'b1;
            we_d  = we;
            adr_d = adr;
            dat_d = we ? dat_w : 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= 32'h0;
            dat_q   <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            stb_q   <= stb_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            rdata_q <= rdata_d;
        end
    end

    assign stb_o    = stb_q;
    assign we_o     = we_q;
    assign adr_o    = adr_q;
    assign dat_o    = dat_q;
    assign rdata    = rdata_q;
    assign done     = hit;
    assign err_done = hit & err_eff;

endmodule

// File: rtl/sd_ext_wb.sv
// -----------------------------------------------------------------------------
// sd_ext_wb
// Moves 512-byte blocks between local dual-port buffers and a Wishbone bus,
// one classic single-word access at a time, with cyc held for the block.
//
// Parameters:
//   BASE_ADDR    Wishbone byte address of block 0
//   BLOCK_WORDS  32-bit words per block
//
// Ports:
//   clk_50, reset                      clock / synchronous active-high reset
//   ext_read_act/addr/stop, ext_read_go    block-read request handshake
//   ext_write_act/addr, ext_write_done     block-write request handshake
//   bram_rd_ext_addr/wren/data         write port of the read buffer
//   bram_wr_ext_addr, bram_wr_ext_q    read port of the write buffer
//                                      (data one cycle after the address)
//   wbm_*                              classic Wishbone master
//   xfer_err                           sticky bus-error flag
//
// Build option: SD_EXT_WB_ERR_EN enables bus-error termination and the
// sticky xfer_err flag; when undefined, wbm_err_i is ignored and xfer_err=0.
// -----------------------------------------------------------------------------
module sd_ext_wb
    import sd_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          BLOCK_WORDS = SD_BLOCK_WORDS
) (
    input  logic        clk_50,
    input  logic        reset,
    input  logic        ext_read_act,
    input  logic [31:0] ext_read_addr,
    input  logic        ext_read_stop,
    output logic        ext_read_go,
    input  logic        ext_write_act,
    input  logic [31:0] ext_write_addr,
    output logic        ext_write_done,
    output logic [6:0]  bram_rd_ext_addr,
    output logic        bram_rd_ext_wren,
    output logic [31:0] bram_rd_ext_data,
    output logic [6:0]  bram_wr_ext_addr,
    input  logic [31:0] bram_wr_ext_q,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    output logic        xfer_err
);

    localparam logic [6:0] LAST_WORD = 7'(BLOCK_WORDS - 1);

    sd_state_t   state_q, state_d;
    logic [31:0] blk_q, blk_d;
    logic [6:0]  cnt_q, cnt_d;
    logic        cyc_q, cyc_d;
    logic        go_q, go_d;
    logic        done_q, done_d;

    logic        eng_start;
    logic        eng_we;
    logic [31:0] eng_adr;
    logic        eng_done;
    logic        eng_err;
    logic [31:0] eng_rdata;
    logic        last_word;

    assign last_word = (cnt_q == LAST_WORD);
    assign eng_start = (state_q == RD_BUS) || (state_q == WR_BUS);
    assign eng_we    = (state_q == WR_BUS);
    assign eng_adr   = sd_word_addr(BASE_ADDR, blk_q, cnt_q);

    // The write buffer address is held at the current word from WR_FETCH
    // through WR_BUS, so its registered output is still valid when the
    // engine samples it at the start of the bus access.
    sd_wb_single u_wb (
        .clk      (clk_50),
        .reset    (reset),
        .start    (eng_start),
        .we       (eng_we),
        .adr      (eng_adr),
        .dat_w    (bram_wr_ext_q),
        .stb_o    (wbm_stb_o),
        .we_o     (wbm_we_o),
        .adr_o    (wbm_adr_o),
        .dat_o    (wbm_dat_o),
        .dat_i    (wbm_dat_i),
        .ack_i    (wbm_ack_i),
        .err_i    (wbm_err_i),
        .done     (eng_done),
        .err_done (eng_err),
        .rdata    (eng_rdata)
    );

    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        cnt_d   = cnt_q;
        cyc_d   = cyc_q;
        go_d    = go_q;
        done_d  = done_q;
        case (state_q)
            IDLE: begin
                // Reads take priority over a simultaneous write request.
                if (ext_read_act) begin
                    blk_d   = ext_read_addr;
                    cnt_d   = 7'd0;
                    cyc_d   = 1'b1;
                    state_d = RD_BUS;
                end else if (ext_write_act && !done_q) begin
                    blk_d   = ext_write_addr;
                    cnt_d   = 7'd0;
                    cyc_d   = 1'b1;
                    state_d = WR_FETCH;
                end
            end
            RD_BUS: begin
                if (eng_done) begin
                    state_d = RD_STORE;
                end
            end
            RD_STORE: begin
                cnt_d = cnt_q + 7'd1;
                if (last_word) begin
                    cyc_d   = 1'b0;
                    go_d    = 1'b1;
                    state_d = RD_GO;
                end else begin
                    state_d = RD_BUS;
                end
            end
            RD_GO: begin
                if (ext_read_stop) begin
                    go_d = 1'b0;
                end
                // Leave only after the handshake completed and the requester
                // has released both act and stop, so a lingering act cannot
                // retrigger the same block.
                if (!go_q && !ext_read_act && !ext_read_stop) begin
                    state_d = IDLE;
                end
            end
            WR_FETCH: begin
                state_d = WR_LAT;
            end
            WR_LAT: begin
                state_d = WR_BUS;
            end
            WR_BUS: begin
                if (eng_done) begin
                    if (last_word) begin
                        cyc_d   = 1'b0;
                        done_d  = 1'b1;
                        state_d = WR_DONE;
                    end else begin
                        cnt_d   = cnt_q + 7'd1;
                        state_d = WR_FETCH;
                    end
                end
            end
            WR_DONE: begin
                if (!ext_write_act) begin
                    done_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cyc_d   = 1'b0;
                go_d    = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_50) begin
        if (reset) begin
            state_q <= IDLE;
            blk_q   <= 32'h0;
            cnt_q   <= 7'd0;
            cyc_q   <= 1'b0;
            go_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            cnt_q   <= cnt_d;
            cyc_q   <= cyc_d;
            go_q    <= go_d;
            done_q  <= done_d;
        end
    end

`ifdef SD_EXT_WB_ERR_EN
    logic xfer_err_q, xfer_err_d;

    always_comb begin
        xfer_err_d = xfer_err_q;
        if (eng_err) begin
            xfer_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_50) begin
        if (reset) begin
            xfer_err_q <= 1'b0;
        end else begin
            xfer_err_q <= xfer_err_d;
        end
    end

    assign xfer_err = xfer_err_q;
`else
    logic unused_eng_err;
    assign unused_eng_err = eng_err;
    assign xfer_err       = 1'b0;
`endif

    assign bram_rd_ext_addr = cnt_q;
    assign bram_rd_ext_wren = (state_q == RD_STORE);
    assign bram_rd_ext_data = eng_rdata;
    assign bram_wr_ext_addr = cnt_q;
    assign wbm_cyc_o        = cyc_q;
    assign wbm_sel_o        = 4'hF;
    assign ext_read_go      = go_q;
    assign ext_write_done   = done_q;

endmodule

// File: doc/sd_ext_wb.md
SD_EXT_WB -- requirements
Module: sd_ext_wb

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the Wishbone byte address of block 0.
REQ-002 SHALL have parameter BLOCK_WORDS, default 128, meaning the number of 32-bit words per 512-byte block.
REQ-003 Ports:
- clk_50  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- ext_read_act  in  1  block-read request.
- ext_read_addr  in  32  block number to read.
- ext_read_stop  in  1  requester has seen go.
- ext_read_go  out  1  read block is loaded in the buffer.
- ext_write_act  in  1  block-write request.
- ext_write_addr  in  32  block number to write.
- ext_write_done  out  1  write block has been flushed.
- bram_rd_ext_addr  out  7  word index into the read buffer.
- bram_rd_ext_wren  out  1  write strobe for the read buffer.
- bram_rd_ext_data  out  32  data into the read buffer.
- bram_wr_ext_addr  out  7  word index into the write buffer.
- bram_wr_ext_q  in  32  write-buffer data; valid 1 cycle after the address is presented.
- wbm_adr_o  out  32  Wishbone byte address.
- wbm_dat_o  out  32  Wishbone write data.
- wbm_dat_i  in  32  Wishbone read data.
- wbm_we_o  out  1  Wishbone write enable.
- wbm_sel_o  out  4  Wishbone byte selects; constant 4'hF.
- wbm_cyc_o  out  1  Wishbone cycle.
- wbm_stb_o  out  1  Wishbone strobe.
- wbm_ack_i  in  1  Wishbone acknowledge.
- wbm_err_i  in  1  Wishbone error.
- xfer_err  out  1  sticky bus-error flag.

Function
REQ-004 The block SHALL use the states IDLE, RD_BUS, RD_STORE, RD_GO, WR_FETCH, WR_LAT, WR_BUS, WR_DONE.
REQ-005 In IDLE, with ext_read_act=1, the block SHALL latch the block number, clear the word counter and go to RD_BUS; ext_read_act SHALL win if both requests are high.
REQ-006 In IDLE, with only ext_write_act=1 and ext_write_done already 0, the block SHALL latch the block number, clear the counter and go to WR_FETCH.
REQ-007 Wishbone address SHALL be BASE_ADDR + {block,9'b0} + {word,2'b0}, computed modulo 2^32 (wrap-around permitted).
REQ-008 wbm_cyc_o SHALL stay high for the whole block transfer.
REQ-009 wbm_stb_o SHALL stay high until the first cycle in which wbm_ack_i is sampled, then go low for at least one cycle before the next word.
REQ-010 RD_BUS: stb=1, we=0; on ack, wbm_dat_i SHALL be registered and the block SHALL go to RD_STORE.
REQ-011 RD_STORE: bram_rd_ext_wren=1 for exactly one cycle with addr=word and the registered data; the counter SHALL increment; after word BLOCK_WORDS-1 the block SHALL drop cyc and go to RD_GO, otherwise return to RD_BUS.
REQ-012 RD_GO: ext_read_go=1 SHALL hold until ext_read_stop=1 is sampled; go SHALL then fall; the block SHALL return to IDLE only when ext_read_act=0 and ext_read_stop=0 (a new act while stop is still high is not restarted).
REQ-013 WR_FETCH SHALL drive bram_wr_ext_addr=word; WR_LAT SHALL wait one cycle; WR_BUS SHALL capture bram_wr_ext_q into wbm_dat_o and drive stb=1, we=1 until ack.
REQ-014 After ack on word BLOCK_WORDS-1, the block SHALL drop cyc and go to WR_DONE; after any other word it SHALL return to WR_FETCH.
REQ-015 WR_DONE: ext_write_done=1 SHALL hold until ext_write_act=0 is sampled, then the block SHALL return to IDLE.
REQ-016 ext_read_go and ext_write_done SHALL be registered and glitch-free, and each SHALL remain low in every state other than its own done state.
REQ-017 The word counter SHALL be 7 bits wide.

Reset
REQ-018 With reset=1 at a clock edge, all outputs SHALL be 0 on the next cycle except wbm_sel_o=4'hF; state SHALL be IDLE, the counter 0 and xfer_err 0.
REQ-019 Reset mid-transfer SHALL abandon the transfer and drop cyc/stb immediately, with no further buffer writes; the transfer SHALL not resume.

Configuration
REQ-020 With SD_EXT_WB_ERR_EN defined, wbm_err_i=1 SHALL terminate the word like ack, set xfer_err (cleared only by reset), write data 32'h0 for reads, and let the block complete normally.
REQ-021 Without SD_EXT_WB_ERR_EN, wbm_err_i SHALL be ignored and xfer_err SHALL be tied to 0.

Structure
REQ-022 Package sd_pkg SHALL hold the state enum, SD_BLOCK_WORDS=128 and SD_BLOCK_SHIFT=9.
REQ-023 One sub-module, sd_wb_single, SHALL implement the single-word classic Wishbone transaction engine (stb/ack/err handling, data registration).

Verification
REQ-024 Read: ext_read_act=1, addr=5, BASE_ADDR=0, zero-wait slave returning data=address -> 128 buffer writes with word n containing 32'hA00+4n, go rises, and go falls after ext_read_stop.
REQ-025 Write: buffer preloaded with word n=n, ext_write_addr=2 -> 128 Wishbone writes at 32'h400+4n with data n, done=1 until act falls.
REQ-026 Both act high in IDLE -> read serviced first and no Wishbone write issued before the read handshake completes.
REQ-027 Slave inserting 3 wait states on word 64 -> stb held through the waits, no duplicate or skipped word.
REQ-028 reset pulsed at word 40 of a read -> cyc=0 next cycle, no wren afterwards, go never asserted.
REQ-029 With SD_EXT_WB_ERR_EN, err on word 10 -> xfer_err=1, word 10 stored as 0, go still asserted; without the macro, same stimulus -> xfer_err=0.
